// File: rtl/param_microprocessor.sv
// param_microprocessor: parametrised multi-cycle register-file core.
// Each instruction takes three cycles: FETCH (handshake), EXEC (ALU into
// holding registers) and WB (commit). Instruction word, MSB to LSB:
// {opcode[3:0], rd[RA_W], rs[RA_W], imm[DATA_W]}.
// Optional feature macro: MP_CARRY_FLAG_EN adds the carry_flag output and
// enables opcode D (ADC). Without it, opcode D executes as a NOP.
module param_microprocessor #(
    parameter  int DATA_W  = 8,
    parameter  int REG_CNT = 4,
    parameter  int PC_W    = 8,
    localparam int RA_W    = $clog2(REG_CNT),
    localparam int INSTR_W = 4 + 2 * RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               zero_flag,
    output logic               overflow_flag,
    output logic [PC_W-1:0]    pc,
`ifdef MP_CARRY_FLAG_EN
    output logic               carry_flag,
`endif
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_WB     = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ADDI = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_MOV  = 4'hC,
        OP_ADC  = 4'hD,
        OP_RSV  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    // The arithmetic sums carry one extra bit only when the carry flag exists.
`ifdef MP_CARRY_FLAG_EN
    localparam int SUM_W = DATA_W + 1;
`else
    localparam int SUM_W = DATA_W;
`endif

    // Architectural and pipeline state
    state_t              r_state;
    logic [INSTR_W-1:0]  r_instr;
    logic [DATA_W-1:0]   r_regs [REG_CNT];
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_valid;
    logic                r_zero;
    logic                r_ovf;
    logic                r_halted;

    // Holding registers between EXEC and WB
    logic [DATA_W-1:0]   r_hold_res;
    logic                r_hold_ovf;
    logic                r_hold_wr;
    logic                r_hold_halt;
    logic [PC_W-1:0]     r_hold_pc;

`ifdef MP_CARRY_FLAG_EN
    logic                r_carry;
    logic                r_hold_carry;
    logic                w_alu_carry;
    logic [SUM_W-1:0]    w_adc_sum;
`endif

    // Decoded fields of the latched instruction
    opcode_t             w_op;
    logic [RA_W-1:0]     w_rd;
    logic [RA_W-1:0]     w_rs;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [PC_W-1:0]     w_imm_pc;
    logic [PC_W-1:0]     w_pc_inc;
    logic [SUM_W-1:0]    w_add_sum;
    logic [SUM_W-1:0]    w_addi_sum;
    logic [SUM_W-1:0]    w_sub_diff;

    // ALU outputs captured into the holding registers at the end of EXEC
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_ovf;
    logic                w_alu_wr;
    logic                w_alu_halt;
    logic [PC_W-1:0]     w_next_pc;

    assign w_op  = opcode_t'(r_instr[INSTR_W-1 -: 4]);
    assign w_rd  = r_instr[INSTR_W-5 -: RA_W];
    assign w_rs  = r_instr[DATA_W +: RA_W];
    assign w_imm = r_instr[DATA_W-1:0];
    assign w_a   = r_regs[w_rd];
    assign w_b   = r_regs[w_rs];

    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_add_sum  = SUM_W'(w_a) + SUM_W'(w_b);
    assign w_addi_sum = SUM_W'(w_a) + SUM_W'(w_imm);
    assign w_sub_diff = SUM_W'(w_a) - SUM_W'(w_b);
`ifdef MP_CARRY_FLAG_EN
    assign w_adc_sum  = SUM_W'(w_a) + SUM_W'(w_b) + SUM_W'(r_carry);
`endif

    // Jump targets: truncate a wide immediate, zero-extend a narrow one.
    if (PC_W <= DATA_W) begin : g_pc_trunc
        assign w_imm_pc = w_imm[PC_W-1:0];
    end else begin : g_pc_zext
        assign w_imm_pc = {{(PC_W - DATA_W){1'b0}}, w_imm};
    end

    // Signed overflow from operand and result sign bits. With a carry-in the
    // same rule still holds, because it judges the full sum.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    // Combinational ALU and next-pc selection for the latched instruction
    always_comb begin
        // NOTE: every signal gets a default here, so no path can infer a latch.
        w_alu_res  = w_a;
        w_alu_ovf  = 1'b0;
        w_alu_wr   = 1'b0;
        w_alu_halt = 1'b0;
        w_next_pc  = w_pc_inc;
`ifdef MP_CARRY_FLAG_EN
        w_alu_carry = 1'b0;
`endif
        case (w_op)
            OP_LDI: begin
                w_alu_res = w_imm;
                w_alu_wr  = 1'b1;
            end
            OP_ADD: begin
                w_alu_res = w_add_sum[DATA_W-1:0];
                w_alu_ovf = add_ovf(w_a[DATA_W-1], w_b[DATA_W-1], w_add_sum[DATA_W-1]);
                w_alu_wr  = 1'b1;
`ifdef MP_CARRY_FLAG_EN
                w_alu_carry = w_add_sum[DATA_W];
`endif
            end
            OP_SUB: begin
                w_alu_res = w_sub_diff[DATA_W-1:0];
                w_alu_ovf = sub_ovf(w_a[DATA_W-1], w_b[DATA_W-1], w_sub_diff[DATA_W-1]);
                w_alu_wr  = 1'b1;
`ifdef MP_CARRY_FLAG_EN
                // Zero-extended subtraction: the top bit is the unsigned borrow.
                w_alu_carry = w_sub_diff[DATA_W];
`endif
            end
            OP_AND: begin
                w_alu_res = w_a & w_b;
                w_alu_wr  = 1'b1;
            end
            OP_OR: begin
                w_alu_res = w_a | w_b;
                w_alu_wr  = 1'b1;
            end
            OP_XOR: begin
                w_alu_res = w_a ^ w_b;
                w_alu_wr  = 1'b1;
            end
            OP_SHL: begin
                w_alu_res = {w_a[DATA_W-2:0], 1'b0};
                w_alu_wr  = 1'b1;
            end
            OP_SHR: begin
                w_alu_res = {1'b0, w_a[DATA_W-1:1]};
                w_alu_wr  = 1'b1;
            end
            OP_ADDI: begin
                w_alu_res = w_addi_sum[DATA_W-1:0];
                w_alu_ovf = add_ovf(w_a[DATA_W-1], w_imm[DATA_W-1], w_addi_sum[DATA_W-1]);
                w_alu_wr  = 1'b1;
`ifdef MP_CARRY_FLAG_EN
                w_alu_carry = w_addi_sum[DATA_W];
`endif
            end
            OP_JMP: begin
                w_next_pc = w_imm_pc;
            end
            OP_JZ: begin
                w_next_pc = r_zero ? w_imm_pc : w_pc_inc;
            end
            OP_MOV: begin
                w_alu_res = w_b;
                w_alu_wr  = 1'b1;
            end
`ifdef MP_CARRY_FLAG_EN
            OP_ADC: begin
                w_alu_res   = w_adc_sum[DATA_W-1:0];
                w_alu_ovf   = add_ovf(w_a[DATA_W-1], w_b[DATA_W-1], w_adc_sum[DATA_W-1]);
                w_alu_carry = w_adc_sum[DATA_W];
                w_alu_wr    = 1'b1;
            end
`endif
            OP_HALT: begin
                // The pc keeps the address of the HALT instruction.
                w_next_pc  = r_pc;
                w_alu_halt = 1'b1;
            end
            default: begin
                // NOP, reserved, and ADC when the carry feature is absent
            end
        endcase
    end

    // FETCH/EXEC/WB sequencer with architectural state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is reset explicitly because programs may
            // read a register before writing it. That is why it lives in flops
            // and not in RAM.
            for (int i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= '0;
            end
            r_state        <= ST_FETCH;
            r_instr        <= '0;
            r_pc           <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_zero         <= 1'b0;
            r_ovf          <= 1'b0;
            r_halted       <= 1'b0;
            r_hold_res     <= '0;
            r_hold_ovf     <= 1'b0;
            r_hold_wr      <= 1'b0;
            r_hold_halt    <= 1'b0;
            r_hold_pc      <= '0;
`ifdef MP_CARRY_FLAG_EN
            r_carry        <= 1'b0;
            r_hold_carry   <= 1'b0;
`endif
        end else begin
            // The result strobe lasts one cycle. Only WB sets it again.
            r_result_valid <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_hold_res  <= w_alu_res;
                    r_hold_ovf  <= w_alu_ovf;
                    r_hold_wr   <= w_alu_wr;
                    r_hold_halt <= w_alu_halt;
                    r_hold_pc   <= w_next_pc;
`ifdef MP_CARRY_FLAG_EN
                    r_hold_carry <= w_alu_carry;
`endif
                    r_state     <= ST_WB;
                end
                ST_WB: begin
                    if (r_hold_wr) begin
                        r_regs[w_rd]   <= r_hold_res;
                        r_result       <= r_hold_res;
                        r_zero         <= (r_hold_res == '0);
                        r_ovf          <= r_hold_ovf;
                        r_result_valid <= 1'b1;
`ifdef MP_CARRY_FLAG_EN
                        r_carry        <= r_hold_carry;
`endif
                    end
                    r_pc <= r_hold_pc;
                    if (r_hold_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALTED;
                    end else begin
                        r_state  <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    // Everything is held until rst.
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign instr_ready   = (r_state == ST_FETCH) && !rst;
    assign result        = r_result;
    assign result_valid  = r_result_valid;
    assign zero_flag     = r_zero;
    assign overflow_flag = r_ovf;
    assign pc            = r_pc;
    assign halted        = r_halted;
`ifdef MP_CARRY_FLAG_EN
    assign carry_flag    = r_carry;
`endif

endmodule

// File: tb/tb_param_microprocessor.sv
// tb_param_microprocessor: self-checking bench for param_microprocessor.
// Directed programs plus randomized instructions, checked against an
// instruction-level reference model. Carry checks apply when
// MP_CARRY_FLAG_EN is defined.
module tb_param_microprocessor;

    localparam int DW  = 8;
    localparam int RC  = 4;
    localparam int PW  = 8;
    localparam int RAW = 2;
    localparam int IW  = 4 + 2 * RAW + DW;
    localparam int DMOD = 1 << DW;
    localparam int PMOD = 1 << PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] instr = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          zero_flag;
    logic          overflow_flag;
    logic [PW-1:0] pc;
    logic          halted;
`ifdef MP_CARRY_FLAG_EN
    logic          carry_flag;
`endif

    param_microprocessor #(.DATA_W(DW), .REG_CNT(RC), .PC_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .result        (result),
        .result_valid  (result_valid),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .pc            (pc),
`ifdef MP_CARRY_FLAG_EN
        .carry_flag    (carry_flag),
`endif
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: architectural state only, one call per instruction
    int m_regs [RC];
    int m_pc, m_result, m_z, m_v, m_c, m_halted;
    int m_rv_cnt = 0;
    int rv_seen  = 0;

    always @(posedge clk) if (result_valid === 1'b1) rv_seen++;

    function automatic int sgn(input int x);
        return (x >= DMOD / 2) ? x - DMOD : x;
    endfunction

    function automatic bit out_of_range(input int s);
        return (s < -(DMOD / 2)) || (s > DMOD / 2 - 1);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RC; i++) m_regs[i] = 0;
        m_pc = 0; m_result = 0; m_z = 0; m_v = 0; m_c = 0; m_halted = 0;
    endtask

    task automatic m_exec(input logic [IW-1:0] ins, output bit wr);
        int op, rd, rs, imm, a, b, r, npc;
        bit ov, cy;
        op  = int'(ins[IW-1 -: 4]);
        rd  = int'(ins[IW-5 -: RAW]);
        rs  = int'(ins[DW +: RAW]);
        imm = int'(ins[DW-1:0]);
        a = m_regs[rd];
        b = m_regs[rs];
        r = 0; wr = 0; ov = 0; cy = 0;
        npc = (m_pc + 1) % PMOD;
        case (op)
            1:  begin r = imm; wr = 1; end
            2:  begin r = a + b; cy = (r >= DMOD); ov = out_of_range(sgn(a) + sgn(b)); r = r % DMOD; wr = 1; end
            3:  begin cy = (a < b); ov = out_of_range(sgn(a) - sgn(b)); r = (a - b + DMOD) % DMOD; wr = 1; end
            4:  begin r = a & b; wr = 1; end
            5:  begin r = a | b; wr = 1; end
            6:  begin r = a ^ b; wr = 1; end
            7:  begin r = (a * 2) % DMOD; wr = 1; end
            8:  begin r = a / 2; wr = 1; end
            9:  begin r = a + imm; cy = (r >= DMOD); ov = out_of_range(sgn(a) + sgn(imm)); r = r % DMOD; wr = 1; end
            10: npc = imm % PMOD;
            11: if (m_z != 0) npc = imm % PMOD;
            12: begin r = b; wr = 1; end
`ifdef MP_CARRY_FLAG_EN
            13: begin r = a + b + m_c; cy = (r >= DMOD); ov = out_of_range(sgn(a) + sgn(b) + m_c); r = r % DMOD; wr = 1; end
`endif
            15: begin npc = m_pc; m_halted = 1; end
            default: ;
        endcase
        if (wr) begin
            m_regs[rd] = r;
            m_result = r;
            m_z = (r == 0);
            m_v = ov;
            m_c = cy;
            m_rv_cnt++;
        end
        m_pc = npc;
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int rd, input int rs, input int imm);
        logic [IW-1:0] w;
        w = {op[3:0], rd[RAW-1:0], rs[RAW-1:0], imm[DW-1:0]};
        return w;
    endfunction

    // Offer one instruction, follow it through EXEC and WB, then compare the
    // outputs with the model. Junk with random valid is driven while the core
    // is busy and must be ignored.
    task automatic issue(input logic [IW-1:0] ins, input string tag);
        int waited;
        bit exp_rv;
        waited = 0;
        instr = ins;
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        check({tag, ".accept"}, instr_ready, 1);
        if (instr_ready !== 1'b1) begin
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        instr = IW'($urandom);
        instr_valid = 1'($urandom_range(0, 1));
        check({tag, ".busy_ready"}, instr_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".early_rv"}, result_valid, 0);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        m_exec(ins, exp_rv);
        check({tag, ".rv"},     result_valid, exp_rv);
        check({tag, ".result"}, result, m_result);
        check({tag, ".zero"},   zero_flag, m_z);
        check({tag, ".ovf"},    overflow_flag, m_v);
        check({tag, ".pc"},     pc, m_pc);
        check({tag, ".halted"}, halted, m_halted);
`ifdef MP_CARRY_FLAG_EN
        check({tag, ".carry"},  carry_flag, m_c);
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk); @(negedge clk);
        end
        check("rst.ready_low", instr_ready, 0);
        check("rst.rv_low", result_valid, 0);
        rst = 1'b0;
        m_reset();
        #1;
        check("rst.ready_high", instr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();

        // Reset then idle: nothing moves and no strobe
        do_reset(2);
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            check("idle.rv", result_valid, 0);
            check("idle.ready", instr_ready, 1);
        end
        check("idle.pc", pc, 0);
        check("idle.result", result, 0);
        check("idle.flags", {zero_flag, overflow_flag, halted}, 0);

        // Signed overflow on ADD
        issue(mk(1, 0, 0, 'h7F), "ldi_r0");
        issue(mk(1, 1, 0, 'h01), "ldi_r1");
        issue(mk(2, 0, 1, 0), "add_r0r1");
        check("dir.add_result", result, 'h80);
        check("dir.add_ovf", overflow_flag, 1);
        check("dir.add_pc", pc, 3);

        // SUB to zero, then a taken JZ
        issue(mk(1, 2, 0, 'h05), "ldi_r2");
        issue(mk(3, 2, 2, 0), "sub_r2r2");
        check("dir.sub_zero", zero_flag, 1);
        issue(mk(11, 0, 0, 'h10), "jz");
        check("dir.jz_pc", pc, 'h10);
        check("dir.jz_result", result, 0);

        // pc wrap from 0xFF
        issue(mk(10, 0, 0, 'hFF), "jmp_ff");
        issue(mk(0, 0, 0, 0), "nop_wrap");
        check("dir.pc_wrap", pc, 0);

        // Random instructions with idle gaps (no HALT)
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); @(negedge clk);
                check("gap.rv", result_valid, 0);
            end
            issue(mk($urandom_range(0, 14), $urandom_range(0, RC - 1),
                     $urandom_range(0, RC - 1), $urandom_range(0, DMOD - 1)), "rand");
        end

        // Reset while an ADD is in EXEC: it must never commit
        issue(mk(1, 0, 0, 'h33), "pre_r0");
        issue(mk(1, 1, 0, 'h44), "pre_r1");
        instr = mk(2, 0, 1, 0);
        instr_valid = 1'b1;
        check("exec_rst.ready", instr_ready, 1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("exec_rst.ready", instr_ready, 0);
        check("exec_rst.pc", pc, 0);
        check("exec_rst.result", result, 0);
        rst = 1'b0;
        m_reset();
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("exec_rst.rv", result_valid, 0);
            check("exec_rst.fetch", instr_ready, 1);
        end
        issue(mk(2, 0, 1, 0), "post_rst_add");
        check("exec_rst.regs_zero", result, 0);

`ifdef MP_CARRY_FLAG_EN
        issue(mk(1, 0, 0, 'hFF), "c_ldi");
        issue(mk(9, 0, 0, 'h01), "c_addi");
        check("carry.addi_res", result, 0);
        check("carry.addi_c", carry_flag, 1);
        issue(mk(13, 0, 0, 0), "c_adc");
        check("carry.adc_res", result, 1);
`endif

        // HALT at pc=4, held for 10 cycles, then released by rst
        do_reset(1);
        for (int i = 0; i < 4; i++) issue(mk(0, 0, 0, 0), "nop");
        issue(mk(15, 0, 0, 0), "halt");
        instr_valid = 1'b1;
        instr = mk(1, 0, 0, 'h5A);
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            check("halt.halted", halted, 1);
            check("halt.pc", pc, 4);
            check("halt.ready", instr_ready, 0);
            check("halt.rv", result_valid, 0);
        end
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check("halt.cleared", halted, 0);
        check("halt.pc_reset", pc, 0);

        @(posedge clk);
        @(negedge clk);
        check("rv_count", rv_seen, m_rv_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
